// File: rtl/corr_sync_ctrl.sv
// Sequencer for the 64-tap preamble correlator: arms it, discards the pipeline
// fill, then thresholds the R metric and reports the windowed peak or a timeout.
module corr_sync_ctrl #(
    parameter int FBIT     = 7,
    parameter int FILL_LEN = 128,
    parameter int WIN      = 16,
    parameter int MAX_SRCH = 4095
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            smp_vld_i,
    output logic            corr_ena_o,
    input  logic            corr_vld_i,
    input  logic [4+FBIT:0] corr_in_i,
    input  logic [4+FBIT:0] thresh_i,
    output logic            busy_o,
    output logic            sync_pulse_o,
    output logic [7:0]      sync_ofs_o,
    output logic [4+FBIT:0] peak_val_o,
    output logic            timeout_o
);
    // state  | meaning
    // IDLE   | disarmed, correlator gated off, stale corr_vld dropped
    // FILL   | discarding FILL_LEN valids while the correlator pipeline fills
    // SEARCH | waiting for corr_in >= threshold, bounded by MAX_SRCH valids
    // PEAK   | tracking the maximum over WIN valids from the crossing
    typedef enum logic [1:0] {IDLE, FILL, SEARCH, PEAK} state_t;

    localparam logic [7:0]  FILL_LAST = 8'(FILL_LEN - 1);
    localparam logic [7:0]  WIN_C     = 8'(WIN);
    localparam logic [15:0] MAX_C     = 16'(MAX_SRCH);

    state_t          state_q;
    logic [7:0]      fill_q;
    logic [15:0]     srch_q;
    logic [7:0]      win_q;
    logic [7:0]      ofs_q;
    logic [4+FBIT:0] max_q;
    logic [4+FBIT:0] thr_q;
    logic            sync_pulse_q;
    logic            timeout_q;
    logic [7:0]      sync_ofs_q;
    logic [4+FBIT:0] peak_val_q;

    logic [7:0]      win_d;
    logic [15:0]     srch_d;
    logic [7:0]      ofs_d;
    logic [4+FBIT:0] max_d;
    logic            hit;
    logic            gt;

    assign hit    = (corr_in_i >= thr_q);
    // Strict compare: the earliest sample of a tied maximum keeps its offset.
    assign gt     = (corr_in_i > max_q);
    assign max_d  = gt ? corr_in_i : max_q;
    assign ofs_d  = gt ? win_q : ofs_q;
    assign win_d  = win_q + 8'd1;
    assign srch_d = srch_q + 16'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            fill_q       <= '0;
            srch_q       <= '0;
            win_q        <= '0;
            ofs_q        <= '0;
            max_q        <= '0;
            thr_q        <= '0;
            sync_pulse_q <= 1'b0;
            timeout_q    <= 1'b0;
            sync_ofs_q   <= '0;
            peak_val_q   <= '0;
        end else begin
            sync_pulse_q <= 1'b0;
            timeout_q    <= 1'b0;
            if (abort_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            thr_q   <= thresh_i;
                            fill_q  <= '0;
                            srch_q  <= '0;
                            win_q   <= '0;
                            state_q <= FILL;
                        end
                    end
                    FILL: begin
                        if (corr_vld_i) begin
                            if (fill_q == FILL_LAST) state_q <= SEARCH;
                            else                     fill_q  <= fill_q + 8'd1;
                        end
                    end
                    SEARCH: begin
                        if (corr_vld_i) begin
                            if (hit) begin
                                max_q <= corr_in_i;
                                ofs_q <= '0;
                                win_q <= 8'd1;
                                if (WIN_C == 8'd1) begin
                                    sync_pulse_q <= 1'b1;
                                    peak_val_q   <= corr_in_i;
                                    sync_ofs_q   <= '0;
                                    state_q      <= IDLE;
                                end else begin
                                    state_q <= PEAK;
                                end
                            end else begin
                                srch_q <= srch_d;
                                if (srch_d == MAX_C) begin
                                    timeout_q <= 1'b1;
                                    state_q   <= IDLE;
                                end
                            end
                        end
                    end
                    PEAK: begin
                        if (corr_vld_i) begin
                            max_q <= max_d;
                            ofs_q <= ofs_d;
                            win_q <= win_d;
                            if (win_d == WIN_C) begin
                                sync_pulse_q <= 1'b1;
                                peak_val_q   <= max_d;
                                sync_ofs_q   <= ofs_d;
                                state_q      <= IDLE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign corr_ena_o   = smp_vld_i & busy_o;
    assign sync_pulse_o = sync_pulse_q;
    assign timeout_o    = timeout_q;
    assign sync_ofs_o   = sync_ofs_q;
    assign peak_val_o   = peak_val_q;

endmodule

// File: tb/tb_corr_sync_ctrl.sv
// Directed bench for corr_sync_ctrl: timeout, peak search, ties, fill masking,
// abort, gapped valids and start collisions, with hand-computed expectations.
module tb_corr_sync_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic        smp_vld_i = 1'b0;
    logic        corr_ena_o;
    logic        corr_vld_i = 1'b0;
    logic [11:0] corr_in_i = '0;
    logic [11:0] thresh_i = '0;
    logic        busy_o;
    logic        sync_pulse_o;
    logic [7:0]  sync_ofs_o;
    logic [11:0] peak_val_o;
    logic        timeout_o;

    int total = 0;
    int bad = 0;
    int n_sync = 0;
    int n_tmo = 0;

    corr_sync_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .smp_vld_i(smp_vld_i), .corr_ena_o(corr_ena_o), .corr_vld_i(corr_vld_i),
        .corr_in_i(corr_in_i), .thresh_i(thresh_i), .busy_o(busy_o),
        .sync_pulse_o(sync_pulse_o), .sync_ofs_o(sync_ofs_o),
        .peak_val_o(peak_val_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (sync_pulse_o) n_sync++;
        if (timeout_o)    n_tmo++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle of stimulus; the following rising edge samples it.
    task automatic cyc(input logic v, input logic [11:0] d);
        @(posedge clk_i); #1;
        start_i = 1'b0; abort_i = 1'b0;
        smp_vld_i = v; corr_vld_i = v; corr_in_i = d;
    endtask

    task automatic arm(input logic [11:0] th);
        @(posedge clk_i); #1;
        start_i = 1'b1; abort_i = 1'b0; thresh_i = th;
        smp_vld_i = 1'b0; corr_vld_i = 1'b0; corr_in_i = '0;
    endtask

    task automatic vg(input logic [11:0] d);
        cyc(1'b1, d); cyc(1'b0, 12'h0); cyc(1'b0, 12'h0);
    endtask

    logic [11:0] ramp [16];
    logic [11:0] ties [16];

    initial begin
        for (int i = 0; i < 16; i++) begin
            ramp[i] = 12'h050;
            ties[i] = 12'h010;
        end
        ramp[0] = 12'h100; ramp[1] = 12'h180; ramp[2] = 12'h240; ramp[3] = 12'h200;
        ties[0] = 12'h100; ties[1] = 12'h120; ties[2] = 12'h200; ties[3] = 12'h300;
        ties[4] = 12'h100; ties[5] = 12'h100; ties[6] = 12'h100; ties[7] = 12'h300;

        repeat (3) cyc(1'b0, 12'h0);
        rst_i = 1'b0;
        cyc(1'b0, 12'h0);
        chk("rst_busy", busy_o, 0);
        chk("rst_sync", sync_pulse_o, 0);
        chk("rst_tmo", timeout_o, 0);
        chk("rst_ofs", sync_ofs_o, 0);
        chk("rst_peak", peak_val_o, 0);

        // stale valids in IDLE: no enable, no arming
        cyc(1'b1, 12'h7FF);
        chk("idle_ena", corr_ena_o, 0);
        cyc(1'b0, 12'h0);
        chk("idle_busy", busy_o, 0);

        // timeout: 128 fill + 4095 non-crossing valids
        arm(12'h100);
        for (int i = 0; i < 128; i++) cyc(1'b1, 12'h0);
        chk("fill_ena", corr_ena_o, 1);
        for (int i = 0; i < 4094; i++) cyc(1'b1, 12'h0);
        cyc(1'b1, 12'h0);
        chk("tmo_pre_busy", busy_o, 1);
        chk("tmo_pre", timeout_o, 0);
        cyc(1'b0, 12'h0);
        chk("tmo_pulse", timeout_o, 1);
        chk("tmo_busy", busy_o, 0);
        // start on the timeout cycle arms normally
        arm(12'h100);
        cyc(1'b0, 12'h0);
        chk("tmo_rearm", busy_o, 1);
        chk("tmo_once", n_tmo, 1);
        chk("tmo_nosync", n_sync, 0);
        chk("tmo_peak_hold", peak_val_o, 0);
        @(posedge clk_i); #1; abort_i = 1'b1;
        cyc(1'b0, 12'h0);
        chk("abort_idle", busy_o, 0);

        // ramp, with above-threshold values during fill that must be ignored
        arm(12'h100);
        for (int i = 0; i < 128; i++) cyc(1'b1, 12'h7FF);
        cyc(1'b1, 12'h0F0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, ramp[i]);
            if (i == 15) begin
                chk("ramp_pre_sync", sync_pulse_o, 0);
                chk("ramp_pre_busy", busy_o, 1);
            end
        end
        cyc(1'b0, 12'h0);
        chk("ramp_sync", sync_pulse_o, 1);
        chk("ramp_peak", peak_val_o, 12'h240);
        chk("ramp_ofs", sync_ofs_o, 2);
        chk("ramp_busy", busy_o, 0);
        cyc(1'b0, 12'h0);
        chk("ramp_one_cycle", sync_pulse_o, 0);
        chk("ramp_hold", peak_val_o, 12'h240);

        // tied maxima at offsets 3 and 7
        arm(12'h100);
        for (int i = 0; i < 128; i++) cyc(1'b1, 12'h0);
        for (int i = 0; i < 16; i++) cyc(1'b1, ties[i]);
        cyc(1'b0, 12'h0);
        chk("tie_sync", sync_pulse_o, 1);
        chk("tie_peak", peak_val_o, 12'h300);
        chk("tie_ofs", sync_ofs_o, 3);

        // abort on the final window valid
        arm(12'h100);
        for (int i = 0; i < 128; i++) cyc(1'b1, 12'h0);
        for (int i = 0; i < 15; i++) cyc(1'b1, 12'h400);
        cyc(1'b1, 12'h7F0);
        abort_i = 1'b1;
        cyc(1'b0, 12'h0);
        chk("abort_sync", sync_pulse_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_peak", peak_val_o, 12'h300);
        chk("abort_ofs", sync_ofs_o, 3);
        chk("sync_count", n_sync, 2);

        // gapped valids with a stray start during fill and search
        arm(12'h100);
        for (int i = 0; i < 128; i++) begin
            vg(12'h7FF);
            if (i == 40) begin
                start_i = 1'b1; thresh_i = 12'h000;
            end
        end
        vg(12'h0F0);
        start_i = 1'b1; thresh_i = 12'h000;
        for (int i = 0; i < 15; i++) vg(ramp[i]);
        cyc(1'b1, ramp[15]);
        cyc(1'b0, 12'h0);
        chk("gap_sync", sync_pulse_o, 1);
        chk("gap_peak", peak_val_o, 12'h240);
        chk("gap_ofs", sync_ofs_o, 2);
        // start on the sync cycle arms normally
        start_i = 1'b1; thresh_i = 12'h100;
        cyc(1'b0, 12'h0);
        chk("sync_rearm", busy_o, 1);

        // reset mid-operation
        for (int i = 0; i < 20; i++) cyc(1'b1, 12'h0);
        rst_i = 1'b1;
        cyc(1'b0, 12'h0);
        rst_i = 1'b0;
        chk("mrst_busy", busy_o, 0);
        chk("mrst_peak", peak_val_o, 0);
        chk("mrst_ofs", sync_ofs_o, 0);
        chk("mrst_sync", sync_pulse_o, 0);
        cyc(1'b0, 12'h0);
        chk("final_sync_count", n_sync, 3);
        chk("final_tmo_count", n_tmo, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
